branch_resolve_unit: RTL

- Parametrised, registered successor to the combinational branch comparator; it sits at the EX/MEM boundary of the MIPS pipeline.
- Resolves conditional branches (signed and unsigned compares) and computes the target.
- Holds a 2-bit saturating branch history table (BHT) that serves fetch-stage predictions and is trained on every resolved branch.
- Flags mispredicts and supplies the redirect PC one cycle after issue.

---
 rtl/branch_resolve_unit_if.sv | 56 +++++
 rtl/branch_resolve_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
// Bus between the EX stage / fetch stage and branch_resolve_unit.
// The master side issues branches and fetch lookups; the slave side is the
// resolve unit. Optional statistics outputs exist only when BRANCH_STATS_EN
// is defined.
interface branch_resolve_unit_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    // Issue side
    logic              in_valid;
    logic              branch_flag;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [15:0]       target;
    logic [PC_W-1:0]   next_pc;
    logic              pred_in;
    logic              stall;
    logic              flush;

    // Fetch-stage prediction
    logic [PC_W-1:0]   lookup_pc;
    logic              pred_taken;

    // Registered result
    logic              out_valid;
    logic              taken;
    logic [PC_W-1:0]   branch_address;
    logic [PC_W-1:0]   redirect_pc;
    logic              mispredict;

`ifdef BRANCH_STATS_EN
    logic [31:0]       branch_count;
    logic [31:0]       mispredict_count;
`endif

    modport master (
        output in_valid, branch_flag, alu_op, data1, data2, target, next_pc,
               pred_in, stall, flush, lookup_pc,
`ifdef BRANCH_STATS_EN
        input  branch_count, mispredict_count,
`endif
        input  pred_taken, out_valid, taken, branch_address, redirect_pc,
               mispredict
    );

    modport slave (
        input  in_valid, branch_flag, alu_op, data1, data2, target, next_pc,
               pred_in, stall, flush, lookup_pc,
`ifdef BRANCH_STATS_EN
        output branch_count, mispredict_count,
`endif
        output pred_taken, out_valid, taken, branch_address, redirect_pc,
               mispredict
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch resolver for the EX/MEM boundary.
// Evaluates signed/unsigned branch conditions, computes the branch target,
// registers the result (one cycle latency, stall/flush aware), flags
// mispredicts against the fetch prediction, and keeps a 2-bit saturating
// branch history table trained once per consumed result.
// Optional feature macro: BRANCH_STATS_EN adds branch_count and
// mispredict_count on the interface.
module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    localparam int BHT_N = 2 ** BHT_IDX_W;

    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_BNE  = 4'b0101;
    localparam logic [3:0] OP_BGT  = 4'b0110;
    localparam logic [3:0] OP_BLT  = 4'b0111;
    localparam logic [3:0] OP_BGE  = 4'b1000;
    localparam logic [3:0] OP_BLE  = 4'b1001;
    localparam logic [3:0] OP_BGTU = 4'b1010;
    localparam logic [3:0] OP_BLTU = 4'b1011;
    localparam logic [3:0] OP_BGEU = 4'b1100;
    localparam logic [3:0] OP_BLEU = 4'b1101;

    // ------------------------------------------------------------------
    // Condition and target evaluation
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] op_a_s;
    logic signed [DATA_W-1:0] op_b_s;
    logic                     cond_taken;
    logic [PC_W-1:0]          offset_ext;
    logic [PC_W-1:0]          target_addr;
    logic [PC_W-1:0]          redirect_next;

    assign op_a_s = bus.data1;
    assign op_b_s = bus.data2;

    // Word offset is sign extended and scaled to bytes; the add wraps silently.
    assign offset_ext    = {{(PC_W-18){bus.target[15]}}, bus.target, 2'b00};
    assign target_addr   = bus.next_pc + offset_ext;
    assign redirect_next = cond_taken ? target_addr : bus.next_pc;

    // Decode the compare opcode; unknown opcodes never branch.
    always_comb begin
        cond_taken = 1'b0;
        case (bus.alu_op)
            OP_BEQ:  cond_taken = (bus.data1 == bus.data2);
            OP_BNE:  cond_taken = (bus.data1 != bus.data2);
            OP_BGT:  cond_taken = (op_a_s >  op_b_s);
            OP_BLT:  cond_taken = (op_a_s <  op_b_s);
            OP_BGE:  cond_taken = (op_a_s >= op_b_s);
            OP_BLE:  cond_taken = (op_a_s <= op_b_s);
            OP_BGTU: cond_taken = (bus.data1 >  bus.data2);
            OP_BLTU: cond_taken = (bus.data1 <  bus.data2);
            OP_BGEU: cond_taken = (bus.data1 >= bus.data2);
            OP_BLEU: cond_taken = (bus.data1 <= bus.data2);
            default: cond_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result register
    // ------------------------------------------------------------------
    logic                 out_valid_reg;
    logic                 taken_reg;
    logic [PC_W-1:0]      branch_address_reg;
    logic [PC_W-1:0]      redirect_pc_reg;
    logic                 pred_reg;
    // Only the BHT index bits of the captured next_pc are ever needed.
    logic [BHT_IDX_W-1:0] train_idx_reg;
    logic                 consume;
    logic                 mispredict;

    // Capture: flush kills validity only, stall freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg      <= 1'b0;
            taken_reg          <= 1'b0;
            branch_address_reg <= '0;
            redirect_pc_reg    <= '0;
            pred_reg           <= 1'b0;
            train_idx_reg      <= '0;
        end else if (bus.flush) begin
            out_valid_reg      <= 1'b0;
        end else if (!bus.stall) begin
            out_valid_reg      <= bus.in_valid && bus.branch_flag;
            taken_reg          <= cond_taken;
            branch_address_reg <= target_addr;
            redirect_pc_reg    <= redirect_next;
            pred_reg           <= bus.pred_in;
            train_idx_reg      <= bus.next_pc[BHT_IDX_W+1:2];
        end
    end

    // A result is consumed exactly once: on the edge it leaves the register.
    assign consume    = out_valid_reg && !bus.stall && !bus.flush;
    assign mispredict = out_valid_reg && (taken_reg != pred_reg);

    assign bus.out_valid      = out_valid_reg;
    assign bus.taken          = taken_reg;
    assign bus.branch_address = branch_address_reg;
    assign bus.redirect_pc    = redirect_pc_reg;
    assign bus.mispredict     = mispredict;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0] bht_reg [BHT_N];
    logic [1:0] bht_cur;
    logic [1:0] bht_next;

    assign bht_cur = bht_reg[train_idx_reg];

    // Saturating 2-bit counter update for the entry being trained.
    always_comb begin
        bht_next = bht_cur;
        if (taken_reg) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
        end
    end

    // Per-entry counters; each entry resets to weakly not taken.
    genvar gi;
    generate
        for (gi = 0; gi < BHT_N; gi++) begin : g_bht
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bht_reg[gi] <= 2'b01;
                end else if (consume && (train_idx_reg == BHT_IDX_W'(gi))) begin
                    bht_reg[gi] <= bht_next;
                end
            end
        end
    endgenerate

    // Lookup reads the stored value: a same-cycle update is not bypassed.
    assign bus.pred_taken = bht_reg[bus.lookup_pc[BHT_IDX_W+1:2]][1];

`ifdef BRANCH_STATS_EN
    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    logic [31:0] branch_count_reg;
    logic [31:0] mispredict_count_reg;

    // Count consumed branches and consumed mispredicts; both wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count_reg     <= '0;
            mispredict_count_reg <= '0;
        end else if (consume) begin
            branch_count_reg <= branch_count_reg + 32'd1;
            if (mispredict) mispredict_count_reg <= mispredict_count_reg + 32'd1;
        end
    end

    assign bus.branch_count     = branch_count_reg;
    assign bus.mispredict_count = mispredict_count_reg;
`endif

endmodule
